rtc_tick_gen: RTL

RTC_TICK_GEN -- requirements
Module: rtc_tick_gen

---
 rtl/rtc_tick_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/rtc_tick_gen.sv
// Programmable RTC square-wave generator for the CLINT rtc_i input.
// Divisor/enable changes are applied only at a period boundary, so rtc_o stays glitch-free.
module rtc_tick_gen #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 2,
  parameter bit          RESET_EN    = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 cfg_en_i,
  output logic                 rtc_o,
  output logic                 tick_o,
  output logic [DIV_WIDTH-1:0] div_o,
  output logic                 running_o
);

  // ST_RESET holds every output quiet while rst_i is high; it is left on the first clean edge.
  typedef enum logic [1:0] {
    ST_RESET,
    ST_STOPPED,
    ST_RUNNING,
    ST_PENDING
  } state_e;

  localparam logic [DIV_WIDTH-1:0] MIN_DIV   = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] RESET_DIV = (DEFAULT_DIV < 2) ? MIN_DIV : DIV_WIDTH'(DEFAULT_DIV);

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] sh_div_q, sh_div_d;
  logic                 sh_en_q, sh_en_d;

  logic [DIV_WIDTH-1:0] req_div;
  logic [DIV_WIDTH-1:0] half;
  logic                 last;
  logic                 accept;
  logic                 active;

  assign req_div = (cfg_div_i < MIN_DIV) ? MIN_DIV : cfg_div_i;
  assign last    = (cnt_q == div_q - DIV_WIDTH'(1));
  assign accept  = cfg_valid_i && cfg_ready_o;

  // NOTE: every variable gets its hold value first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    sh_div_d = sh_div_q;
    sh_en_d  = sh_en_q;
    case (state_q)
      ST_RESET: begin
        cnt_d   = '0;
        state_d = RESET_EN ? ST_RUNNING : ST_STOPPED;
      end
      ST_STOPPED: begin
        cnt_d = '0;
        if (accept) begin
          div_d   = req_div;
          state_d = cfg_en_i ? ST_RUNNING : ST_STOPPED;
        end
      end
      ST_RUNNING: begin
        cnt_d = last ? '0 : cnt_q + DIV_WIDTH'(1);
        if (accept) begin
          if (last) begin
            div_d   = req_div;
            state_d = cfg_en_i ? ST_RUNNING : ST_STOPPED;
          end else begin
            sh_div_d = req_div;
            sh_en_d  = cfg_en_i;
            state_d  = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (last) begin
          cnt_d   = '0;
          div_d   = sh_div_q;
          state_d = sh_en_q ? ST_RUNNING : ST_STOPPED;
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update from the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      div_q    <= RESET_DIV;
      sh_div_q <= RESET_DIV;
      sh_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      sh_div_q <= sh_div_d;
      sh_en_q  <= sh_en_d;
    end
  end

  // High phase is ceil(N/2) cycles; written without N+1 so the largest divisor cannot overflow.
  assign half        = (div_q >> 1) + {{(DIV_WIDTH-1){1'b0}}, div_q[0]};
  assign active      = (state_q == ST_RUNNING) || (state_q == ST_PENDING);
  assign rtc_o       = active && (cnt_q < half);
  assign tick_o      = active && (cnt_q == '0);
  assign running_o   = active;
  assign cfg_ready_o = (state_q == ST_STOPPED) || (state_q == ST_RUNNING);
  assign div_o       = div_q;

endmodule
